// File: rtl/sfu_ds_arbiter.sv
// sfu_ds_arbiter: round-robin sharing of one SFU and one DS unit among NREQ requesters.
// Ports: clk_i/rst_i clock and async active-high reset; stall_i freezes all sequencing;
//   req_valid_i/req_opcode_i/req_ready_o per-requester accept handshake (one-hot grant);
//   sfu_en_o/ds_en_o/unit_opcode_o/grant_id_o drive the shared units for the op in flight;
//   rsp_valid_o/rsp_err_o one-hot completion pulse to the owner; busy_o high outside IDLE.
module sfu_ds_arbiter #(
  parameter int NREQ = 4,
  parameter int SFU_LAT = 2,
  parameter int DS_LAT = 5,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [6*NREQ-1:0] req_opcode_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic              sfu_en_o,
  output logic              ds_en_o,
  output logic [5:0]        unit_opcode_o,
  output logic [IDW-1:0]    grant_id_o,
  output logic [NREQ-1:0]   rsp_valid_o,
  output logic              rsp_err_o,
  output logic              busy_o
);
  localparam int LMAX = SFU_LAT > DS_LAT ? SFU_LAT : DS_LAT;
  localparam int CW = $clog2(LMAX + 1);
  typedef enum logic [1:0] {IDLE, SFU_RUN, DS_RUN, DONE} state_t;
  // class: 0 illegal, 1 multi-cycle SFU, 2 DS, 3 single-cycle SFU
  function automatic logic [1:0] op_class(input logic [5:0] op);
    return (op == 6'h24 || op == 6'h25) ? 2'd2 :
           (op inside {6'h21, 6'h22, 6'h23, 6'h2B, 6'h2C, 6'h2D}) ? 2'd1 :
           (op == 6'h27 || op == 6'h2A) ? 2'd3 : 2'd0;
  endfunction
  state_t         state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d, id_q, id_d, gnt_idx;
  logic [CW-1:0]  cnt_q, cnt_d, lat_q, lat_d;
  logic [5:0]     op_q, op_d, acc_op;
  logic [1:0]     acc_cls;
  logic           gnt_any;
  // Scan downwards so the candidate closest to rr_q overwrites the others.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid_i[(int'(rr_q) + k) % NREQ]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'((int'(rr_q) + k) % NREQ);
      end
    end
  end
  assign acc_op  = req_opcode_i[6*gnt_idx +: 6];
  assign acc_cls = op_class(acc_op);
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    op_d        = op_q;
    id_d        = id_q;
    lat_d       = lat_q;
    req_ready_o = '0;
    sfu_en_o    = 1'b0;
    ds_en_o     = 1'b0;
    rsp_valid_o = '0;
    rsp_err_o   = 1'b0;
    case (state_q)
      IDLE: begin
        // rst_i gate keeps the combinational grant quiet during an async reset
        if (!stall_i && !rst_i && gnt_any) begin
          req_ready_o = NREQ'(1) << gnt_idx;
          op_d        = acc_op;
          id_d        = gnt_idx;
          rr_d        = IDW'((int'(gnt_idx) + 1) % NREQ);
          cnt_d       = '0;
          lat_d       = acc_cls == 2'd2 ? CW'(DS_LAT) : acc_cls == 2'd1 ? CW'(SFU_LAT) : CW'(1);
          state_d     = acc_cls == 2'd0 ? DONE : acc_cls == 2'd2 ? DS_RUN : SFU_RUN;
        end
      end
      SFU_RUN, DS_RUN: begin
        sfu_en_o = state_q == SFU_RUN && !stall_i;
        ds_en_o  = state_q == DS_RUN && !stall_i;
        if (!stall_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == lat_q - 1'b1) state_d = DONE;
        end
      end
      DONE: begin
        if (!stall_i) begin
          rsp_valid_o = NREQ'(1) << id_q;
          rsp_err_o   = op_class(op_q) == 2'd0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy_o        = state_q != IDLE;
  assign unit_opcode_o = busy_o ? op_q : '0;
  assign grant_id_o    = busy_o ? id_q : '0;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      op_q    <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      op_q    <= op_d;
      id_q    <= id_d;
    end
  end
endmodule
